// File: rtl/poly1305_mac_engine.sv
// Poly1305 one-time MAC engine: acc = ((acc + m) * r) mod 2^130-5 over a block stream.
// The product is built LIMB_W bits of r per cycle and then folded back below 2^131.
module poly1305_mac_engine #(
  parameter int LIMB_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [255:0] key,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_bytes,
  input  logic         blk_last,
  input  logic         verify_en,
  input  logic [127:0] tag_expected,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         tag_ok,
  output logic         busy
);

  localparam int NCHUNK = 128 / LIMB_W;
  localparam logic [4:0] LAST_CHUNK = 5'(NCHUNK - 1);
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam logic [130:0] PRIME = {1'b0, 130'h3_ffffffff_ffffffff_ffffffff_fffffffb};

  typedef enum logic [2:0] {IDLE, READY, ADD, MUL, RED1, RED2, FINAL} state_t;

  state_t state, state_next;

  logic [127:0] r, s;
  logic [130:0] acc;
  logic [129:0] m_reg;
  logic         last_blk, verify;
  logic [127:0] tag_exp;
  logic [259:0] a_sh, prod;
  logic [127:0] r_sh;
  logic [133:0] t;
  logic [4:0]   chunk;

  logic         key_ok, accept;
  logic [4:0]   nbytes;
  logic [127:0] masked;
  logic [129:0] m_pad;
  logic [259:0] partial;
  logic [133:0] fold1;
  logic [130:0] fold2, frozen;
  logic [127:0] tag_new;

  assign key_ok    = key_load && (state == IDLE || state == READY);
  assign blk_ready = (state == READY) && !key_load;
  assign accept    = blk_valid && blk_ready;
  assign busy      = (state == ADD) || (state == MUL) || (state == RED1) ||
                     (state == RED2) || (state == FINAL);
  assign tag_valid = (state == FINAL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (key_load) state_next = READY;
      READY:   if (accept) state_next = ADD;
      ADD:     state_next = MUL;
      MUL:     if (chunk == LAST_CHUNK) state_next = RED1;
      RED1:    state_next = RED2;
      RED2:    state_next = last_blk ? FINAL : READY;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Padded block: bytes at or above the length are dropped and a 1 is placed just above the data.
  always_comb begin
    nbytes = (blk_bytes == 5'd0 || blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
    masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) masked[8*i +: 8] = blk_data[8*i +: 8];
    end
    m_pad = {2'b00, masked} + (130'd1 << {nbytes, 3'b000});
  end

  assign partial = a_sh * {{(260 - LIMB_W){1'b0}}, r_sh[LIMB_W-1:0]};
  assign fold1   = {4'b0000, prod[129:0]} + 134'(prod[259:130]) * 134'd5;
  assign fold2   = {1'b0, t[129:0]} + 131'(t[133:130]) * 131'd5;
  assign frozen  = (fold2 >= PRIME) ? fold2 - PRIME : fold2;
  assign tag_new = 128'(frozen + {3'b000, s});

  // The tag is registered on the last fold so it is already stable while FINAL raises tag_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= '0;
      s        <= '0;
      acc      <= '0;
      m_reg    <= '0;
      last_blk <= 1'b0;
      verify   <= 1'b0;
      tag_exp  <= '0;
      a_sh     <= '0;
      r_sh     <= '0;
      prod     <= '0;
      t        <= '0;
      chunk    <= '0;
      tag      <= '0;
      tag_ok   <= 1'b0;
    end else begin
      if (key_ok) begin
        r      <= key[127:0] & CLAMP;
        s      <= key[255:128];
        acc    <= '0;
        tag    <= '0;
        tag_ok <= 1'b0;
      end
      if (accept) begin
        m_reg    <= m_pad;
        last_blk <= blk_last;
        verify   <= verify_en;
        tag_exp  <= tag_expected;
      end
      case (state)
        ADD: begin
          a_sh  <= 260'(acc) + 260'(m_reg);
          r_sh  <= r;
          prod  <= '0;
          chunk <= '0;
        end
        MUL: begin
          prod  <= prod + partial;
          a_sh  <= a_sh << LIMB_W;
          r_sh  <= r_sh >> LIMB_W;
          chunk <= chunk + 5'd1;
        end
        RED1: t <= fold1;
        RED2: begin
          acc <= fold2;
          if (last_blk) begin
            tag    <= tag_new;
            tag_ok <= verify && (tag_new == tag_exp);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly1305_mac_engine.sv
// Bench for poly1305_mac_engine at LIMB_W=32 and LIMB_W=8, checked against a
// plain modular-arithmetic Poly1305 model and the RFC 8439 vector.
`timescale 1ns/1ps
module tb_poly1305_mac_engine;

  localparam logic [127:0] CLAMP   = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  localparam logic [263:0] PRIME   = (264'd1 << 130) - 264'd5;
  localparam logic [127:0] TAG_RFC = 128'ha927010c_af8b2bc2_c6365130_c11d06a8;
  localparam logic [127:0] S_CONST = 128'h01234567_89abcdef_01234567_89abcdef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, key_load, blk_valid, blk_last, verify_en, sel;
  logic [255:0] key;
  logic [127:0] blk_data, tag_expected;
  logic [4:0]   blk_bytes;
  logic         kl32, kl8, bv32, bv8;
  logic         ready32, ready8, tv32, tv8, ok32, ok8, busy32, busy8;
  logic [127:0] tag32, tag8;
  logic         obs_ready, obs_tv, obs_ok, obs_busy;
  logic [127:0] obs_tag;

  int total = 0;
  int bad = 0;

  logic [255:0]      rfc_key;
  byte unsigned      rfc_msg[$];

  assign kl32 = key_load && !sel;
  assign kl8  = key_load && sel;
  assign bv32 = blk_valid && !sel;
  assign bv8  = blk_valid && sel;

  assign obs_ready = sel ? ready8 : ready32;
  assign obs_tv    = sel ? tv8 : tv32;
  assign obs_ok    = sel ? ok8 : ok32;
  assign obs_busy  = sel ? busy8 : busy32;
  assign obs_tag   = sel ? tag8 : tag32;

  poly1305_mac_engine #(.LIMB_W(32)) dut32 (
    .clk(clk), .reset(reset), .key_load(kl32), .key(key),
    .blk_valid(bv32), .blk_ready(ready32), .blk_data(blk_data), .blk_bytes(blk_bytes),
    .blk_last(blk_last), .verify_en(verify_en), .tag_expected(tag_expected),
    .tag_valid(tv32), .tag(tag32), .tag_ok(ok32), .busy(busy32)
  );

  poly1305_mac_engine #(.LIMB_W(8)) dut8 (
    .clk(clk), .reset(reset), .key_load(kl8), .key(key),
    .blk_valid(bv8), .blk_ready(ready8), .blk_data(blk_data), .blk_bytes(blk_bytes),
    .blk_last(blk_last), .verify_en(verify_en), .tag_expected(tag_expected),
    .tag_valid(tv8), .tag(tag8), .tag_ok(ok8), .busy(busy8)
  );

  // Reference: canonical modular arithmetic straight from the Poly1305 definition.
  function automatic logic [127:0] ref_tag(input logic [255:0] k, input byte unsigned msg[$]);
    logic [263:0] acc, r, s, m;
    int n;
    r = {136'd0, k[127:0] & CLAMP};
    s = {136'd0, k[255:128]};
    acc = '0;
    for (int off = 0; off < msg.size(); off += 16) begin
      n = (msg.size() - off < 16) ? msg.size() - off : 16;
      m = '0;
      for (int i = 0; i < n; i++) m[8*i +: 8] = msg[off + i];
      m = m + (264'd1 << (8 * n));
      acc = ((acc + m) * r) % PRIME;
    end
    acc = acc + s;
    return acc[127:0];
  endfunction

  function automatic int exp_lat();
    return (sel ? 16 : 4) + 4;
  endfunction

  task automatic init_vectors();
    string txt;
    txt = "Cryptographic Forum Research Group";
    rfc_key = 256'h1bf54941_aff6bf4a_fdb20dfb_8a800301_a806d542_fe52447f_336d5557_78bed685;
    rfc_msg.delete();
    for (int i = 0; i < txt.len(); i++) rfc_msg.push_back(txt[i]);
  endtask

  task automatic load_key(input logic [255:0] k);
    @(negedge clk);
    key = k;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Offers one block and returns the cycle (counted from acceptance) at which
  // blk_ready returns, or tag_valid pulses for a last block; -1 on timeout.
  task automatic send_block(input logic [127:0] d, input logic [4:0] nb, input logic lst,
                            input logic ven, input logic [127:0] texp, input int kl_at,
                            input logic [255:0] kl_key, output int cyc);
    int w;
    bit done;
    blk_data = d;
    blk_bytes = nb;
    blk_last = lst;
    verify_en = ven;
    tag_expected = texp;
    blk_valid = 1'b1;
    #1;
    w = 0;
    while (!obs_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data = ~d;
    blk_bytes = 5'($urandom);
    blk_last = ~lst;
    verify_en = ~ven;
    tag_expected = ~texp;
    cyc = 1;
    done = 1'b0;
    while (!done && cyc <= 60) begin
      if (lst ? obs_tv : obs_ready) begin
        done = 1'b1;
      end else begin
        if (cyc == kl_at) begin
          key = kl_key;
          key_load = 1'b1;
        end else begin
          key_load = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    key_load = 1'b0;
    if (!done) cyc = -1;
  endtask

  task automatic run_message(input logic [255:0] k, input byte unsigned msg[$], input logic ven,
                             input logic [127:0] texp, input bit junk,
                             output logic [127:0] got_tag, output logic got_ok,
                             output int lat_min, output int lat_max);
    int nblk, n, cyc;
    logic [127:0] d;
    logic [4:0] nb;
    logic lst;
    load_key(k);
    nblk = (msg.size() + 15) / 16;
    lat_min = 1000;
    lat_max = -1000;
    for (int b = 0; b < nblk; b++) begin
      n = msg.size() - 16 * b;
      if (n > 16) n = 16;
      lst = (b == nblk - 1);
      d = junk ? {$urandom, $urandom, $urandom, $urandom} : 128'd0;
      for (int i = 0; i < n; i++) d[8*i +: 8] = msg[16*b + i];
      nb = 5'(n);
      if (junk && n == 16) begin
        case ($urandom_range(0, 2))
          0: nb = 5'd0;
          1: nb = 5'($urandom_range(17, 31));
          default: nb = 5'd16;
        endcase
      end
      send_block(d, nb, lst, lst ? ven : 1'($urandom),
                 lst ? texp : {$urandom, $urandom, $urandom, $urandom}, 0, '0, cyc);
      if (cyc < lat_min) lat_min = cyc;
      if (cyc > lat_max) lat_max = cyc;
    end
    got_tag = obs_tag;
    got_ok = obs_ok;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_load = 1'b1;
    blk_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    key_load = 1'b0;
    blk_valid = 1'b0;
    #1;
    total++; if (ready32 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready32: got %b want 0", ready32); end
    total++; if (tv32 !== 1'b0) begin bad++; $display("[TB] FAIL reset_tv32: got %b want 0", tv32); end
    total++; if (tag32 !== 128'd0) begin bad++; $display("[TB] FAIL reset_tag32: got %h want 0", tag32); end
    total++; if (ok32 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ok32: got %b want 0", ok32); end
    total++; if (busy32 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy32: got %b want 0", busy32); end
    total++; if (ready8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready8: got %b want 0", ready8); end
    total++; if (tv8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_tv8: got %b want 0", tv8); end
    total++; if (tag8 !== 128'd0) begin bad++; $display("[TB] FAIL reset_tag8: got %h want 0", tag8); end
    total++; if (ok8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_ok8: got %b want 0", ok8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy8: got %b want 0", busy8); end
  endtask

  task automatic test_rfc(input logic which);
    logic [127:0] got;
    logic ok;
    int mn, mx;
    sel = which;
    run_message(rfc_key, rfc_msg, 1'b0, '0, 1'b0, got, ok, mn, mx);
    total++; if (got !== TAG_RFC) begin bad++; $display("[TB] FAIL rfc_tag[sel=%0d]: got %h want %h", which, got, TAG_RFC); end
    total++; if (mn !== exp_lat()) begin bad++; $display("[TB] FAIL rfc_lat_min[sel=%0d]: got %0d want %0d", which, mn, exp_lat()); end
    total++; if (mx !== exp_lat()) begin bad++; $display("[TB] FAIL rfc_lat_max[sel=%0d]: got %0d want %0d", which, mx, exp_lat()); end
  endtask

  task automatic test_verify();
    logic [127:0] got;
    logic ok;
    int mn, mx;
    sel = 1'b0;
    run_message(rfc_key, rfc_msg, 1'b1, TAG_RFC, 1'b0, got, ok, mn, mx);
    total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL verify_match_ok: got %b want 1", ok); end
    run_message(rfc_key, rfc_msg, 1'b1, TAG_RFC ^ 128'd1, 1'b0, got, ok, mn, mx);
    total++; if (ok !== 1'b0) begin bad++; $display("[TB] FAIL verify_flip_ok: got %b want 0", ok); end
    total++; if (got !== TAG_RFC) begin bad++; $display("[TB] FAIL verify_flip_tag: got %h want %h", got, TAG_RFC); end
    run_message(rfc_key, rfc_msg, 1'b0, TAG_RFC, 1'b0, got, ok, mn, mx);
    total++; if (ok !== 1'b0) begin bad++; $display("[TB] FAIL verify_off_ok: got %b want 0", ok); end
  endtask

  task automatic test_freeze();
    byte unsigned msg[$];
    logic [127:0] got;
    logic ok;
    int mn, mx;
    sel = 1'b0;
    for (int i = 0; i < 32; i++) msg.push_back(8'hff);
    run_message({128'd0, 128'd1}, msg, 1'b0, '0, 1'b0, got, ok, mn, mx);
    total++; if (got !== 128'd3) begin bad++; $display("[TB] FAIL freeze_tag: got %h want 3", got); end
  endtask

  task automatic test_partial();
    int cyc;
    sel = 1'b0;
    load_key({128'd0, 128'd1});
    send_block({{15{8'hab}}, 8'h00}, 5'd1, 1'b1, 1'b0, '0, 0, '0, cyc);
    total++; if (obs_tag !== 128'h100) begin bad++; $display("[TB] FAIL partial_tag: got %h want 100", obs_tag); end
    total++; if (cyc !== exp_lat()) begin bad++; $display("[TB] FAIL partial_lat: got %0d want %0d", cyc, exp_lat()); end
  endtask

  task automatic test_zero_r();
    int cyc, hi;
    sel = 1'b0;
    load_key({S_CONST, 128'd0});
    for (int b = 0; b < 3; b++) begin
      send_block({$urandom, $urandom, $urandom, $urandom}, 5'd16, b == 2, 1'b0, '0,
                 (b == 1) ? 3 : 0, rfc_key, cyc);
      if (b == 1) begin
        total++; if (cyc !== exp_lat()) begin bad++; $display("[TB] FAIL kl_in_mul_lat: got %0d want %0d", cyc, exp_lat()); end
      end
    end
    total++; if (obs_tag !== S_CONST) begin bad++; $display("[TB] FAIL zero_r_tag: got %h want %h", obs_tag, S_CONST); end
    blk_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obs_ready) hi++;
    end
    blk_valid = 1'b0;
    total++; if (hi !== 0) begin bad++; $display("[TB] FAIL ready_after_tag: got %0d ready cycles want 0", hi); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_after_tag: got %b want 0", obs_busy); end
    total++; if (obs_tag !== S_CONST) begin bad++; $display("[TB] FAIL tag_held: got %h want %h", obs_tag, S_CONST); end
  endtask

  task automatic test_key_priority();
    sel = 1'b0;
    load_key(rfc_key);
    @(negedge clk);
    key = rfc_key;
    key_load = 1'b1;
    blk_valid = 1'b1;
    blk_last = 1'b1;
    #1;
    total++; if (obs_ready !== 1'b0) begin bad++; $display("[TB] FAIL prio_ready: got %b want 0", obs_ready); end
    @(negedge clk);
    key_load = 1'b0;
    blk_valid = 1'b0;
    #1;
    total++; if (obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL prio_not_accepted: busy got %b want 0", obs_busy); end
    total++; if (obs_ready !== 1'b1) begin bad++; $display("[TB] FAIL prio_ready_after: got %b want 1", obs_ready); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    logic ok;
    int mn, mx, w;
    sel = 1'b1;
    run_message(rfc_key, rfc_msg, 1'b0, '0, 1'b0, got, ok, mn, mx);
    repeat (3) @(negedge clk);
    total++; if (obs_tag !== TAG_RFC || obs_tv !== 1'b0) begin bad++; $display("[TB] FAIL hold_idle: tag %h tv %b want %h tv 0", obs_tag, obs_tv, TAG_RFC); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (obs_tag !== 128'd0) begin bad++; $display("[TB] FAIL reset_idle_tag: got %h want 0", obs_tag); end
    load_key(rfc_key);
    blk_data = {$urandom, $urandom, $urandom, $urandom};
    blk_bytes = 5'd16;
    blk_last = 1'b0;
    blk_valid = 1'b1;
    #1;
    w = 0;
    while (!obs_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    blk_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (obs_busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_in_mul: got %b want 1", obs_busy); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (obs_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_ready: got %b want 0", obs_ready); end
    total++; if (obs_tag !== 128'd0) begin bad++; $display("[TB] FAIL mid_reset_tag: got %h want 0", obs_tag); end
    total++; if (obs_tv !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_tv: got %b want 0", obs_tv); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy: got %b want 0", obs_busy); end
    reset = 1'b0;
    run_message(rfc_key, rfc_msg, 1'b0, '0, 1'b0, got, ok, mn, mx);
    total++; if (got !== TAG_RFC) begin bad++; $display("[TB] FAIL rfc_after_reset: got %h want %h", got, TAG_RFC); end
  endtask

  task automatic test_random();
    logic [255:0] k;
    byte unsigned msg[$];
    int len, mn, mx;
    logic ven, got_ok, want_ok;
    logic [127:0] texp, want, got;
    for (int it = 0; it < 10; it++) begin
      sel = 1'(it % 2);
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
      len = $urandom_range(1, 64);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      want = ref_tag(k, msg);
      ven = 1'($urandom);
      texp = ($urandom_range(0, 1) == 1) ? want : {$urandom, $urandom, $urandom, $urandom};
      want_ok = ven && (texp == want);
      run_message(k, msg, ven, texp, 1'b1, got, got_ok, mn, mx);
      total++; if (got !== want) begin bad++; $display("[TB] FAIL rand_tag[%0d] len=%0d: got %h want %h", it, len, got, want); end
      total++; if (got_ok !== want_ok) begin bad++; $display("[TB] FAIL rand_ok[%0d]: got %b want %b", it, got_ok, want_ok); end
      total++; if (mn !== exp_lat()) begin bad++; $display("[TB] FAIL rand_lat_min[%0d]: got %0d want %0d", it, mn, exp_lat()); end
      total++; if (mx !== exp_lat()) begin bad++; $display("[TB] FAIL rand_lat_max[%0d]: got %0d want %0d", it, mx, exp_lat()); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    key_load = 1'b0;
    blk_valid = 1'b0;
    blk_last = 1'b0;
    verify_en = 1'b0;
    sel = 1'b0;
    key = '0;
    blk_data = '0;
    blk_bytes = '0;
    tag_expected = '0;
    init_vectors();
    test_reset();
    test_rfc(1'b0);
    test_rfc(1'b1);
    test_verify();
    test_freeze();
    test_partial();
    test_zero_r();
    test_key_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
